// File: rtl/varint_pkg.sv
// Shared types, constants and helpers for the streaming varint serializer.
package varint_pkg;

    localparam logic [2:0] WIRE_VARINT = 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        KEY,
        VAL
    } vs_state_e;

    function automatic int varint_max_bytes(int w);
        return (w + 6) / 7;
    endfunction

    // Zigzag at width w: sign fill replaces the arithmetic shift, result masked to w bits.
    function automatic logic [63:0] zigzag(logic [63:0] x, int w);
        logic [63:0] mask;
        logic [63:0] sign_fill;
        mask      = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        sign_fill = x[w-1] ? mask : 64'd0;
        return ((x << 1) ^ sign_fill) & mask;
    endfunction

endpackage

// File: rtl/varint_shift_reg.sv
// Working register for varint emission: presents the low 7-bit group with its
// continuation flag and drops one group per shift.
module varint_shift_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] data,
    input  logic         shift,
    output logic [7:0]   cur_byte,
    output logic         is_last
);

    logic [W-1:0] r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
        end else if (load) begin
            r <= data;
        end else if (shift) begin
            r <= r >> 7;
        end
    end

    assign is_last  = ((r >> 7) == '0);
    assign cur_byte = {!is_last, r[6:0]};

endmodule

// File: rtl/varint_stream_ser.sv
// Streaming varint serializer: optional protobuf key, optional zigzag, one byte
// per cycle with valid/ready backpressure and a running byte counter.
module varint_stream_ser
    import varint_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int FID_W  = 29,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_zigzag,
    input  logic              in_hdr_en,
    input  logic [FID_W-1:0]  in_field_id,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              out_last,
    output logic [CNT_W-1:0]  byte_cnt
);

    localparam int SR_W = (DATA_W > FID_W + 3) ? DATA_W : FID_W + 3;

    vs_state_e         state;
    logic [DATA_W-1:0] val_q;
    logic [DATA_W-1:0] enc_val;
    logic [63:0]       zz_full;
    logic [SR_W-1:0]   sr_data;
    logic              accept;
    logic              out_hs;
    logic              key_done;
    logic              sr_load;
    logic              sr_shift;
    logic              sr_last;

    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    assign zz_full  = zigzag(64'(in_data), DATA_W);
    assign enc_val  = in_zigzag ? zz_full[DATA_W-1:0] : in_data;
    assign key_done = (state == KEY) && out_hs && sr_last;

    // Reloading straight from val_q on the final key handshake avoids a bubble.
    assign sr_load  = accept || key_done;
    assign sr_shift = out_hs && !key_done;
    assign sr_data  = accept ? (in_hdr_en ? SR_W'({in_field_id, WIRE_VARINT}) : SR_W'(enc_val))
                             : SR_W'(val_q);

    varint_shift_reg #(.W(SR_W)) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sr_load),
        .data     (sr_data),
        .shift    (sr_shift),
        .cur_byte (out_byte),
        .is_last  (sr_last)
    );

    assign out_last = (state == VAL) && sr_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            val_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        val_q     <= enc_val;
                        state     <= in_hdr_en ? KEY : VAL;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                KEY: begin
                    if (key_done) begin
                        state <= VAL;
                    end
                end
                VAL: begin
                    if (out_hs && sr_last) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
        end else if (out_hs) begin
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

endmodule
